// File: rtl/lcd_escrita.sv
// Byte-level HD44780 write driver: latches one command/data byte, drives RS/DATA with
// setup time, produces one timed EN pulse with hold, then waits out the execution time.
module lcd_escrita #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned EN_CYC    = 25,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned EXEC_CYC  = 2500,
  parameter int unsigned LONG_CYC  = 82000
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       busy,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_t;

  localparam logic [20:0] SETUP_LD = 21'(SETUP_CYC - 1);
  localparam logic [20:0] EN_LD    = 21'(EN_CYC - 1);
  localparam logic [20:0] HOLD_LD  = 21'(HOLD_CYC - 1);
  // EXEC is left one cycle early so wr_ready is already high at edge k+T.
  localparam logic [20:0] EXEC_LD  = 21'(EXEC_CYC - 2);
  localparam logic [20:0] LONG_LD  = 21'(LONG_CYC - 2);

  state_t      state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        en_q, en_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        long_wait;
  logic        wait_is_one;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b[7:1] == 7'b0000_001) || (b == 8'h01));
  endfunction

  assign long_wait   = is_long_cmd(rs_q, data_q);
  assign wait_is_one = long_wait ? (LONG_CYC == 1) : (EXEC_CYC == 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    en_d    = en_q;
    rs_d    = rs_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (wr_valid && ready_q) begin
          rs_d    = wr_rs;
          data_d  = wr_data;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 21'd0) begin
          en_d    = 1'b1;
          cnt_d   = EN_LD;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q - 21'd1;
        end
      end
      PULSE: begin
        if (cnt_q == 21'd0) begin
          en_d    = 1'b0;
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 21'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 21'd0) begin
          if (wait_is_one) begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = 21'd0;
            state_d = IDLE;
          end else begin
            cnt_d   = long_wait ? LONG_LD : EXEC_LD;
            state_d = EXEC;
          end
        end else begin
          cnt_d = cnt_q - 21'd1;
        end
      end
      EXEC: begin
        if (cnt_q == 21'd0) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 21'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 21'd0;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 21'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  assign wr_ready = ready_q;
  assign busy     = busy_q;
  assign LCD_EN   = en_q;
  assign LCD_RS   = rs_q;
  assign LCD_DATA = data_q;
  assign LCD_RW   = 1'b0;

endmodule
